// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB/I2C target and its bring-up tooling.
package sccb_pkg;

  // Target FSM states. The read data phase keeps its ACK slot inside ST_RD.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DEV     = 3'd1,
    ST_DEV_ACK = 3'd2,
    ST_REG     = 3'd3,
    ST_REG_ACK = 3'd4,
    ST_WR      = 3'd5,
    ST_WR_ACK  = 3'd6,
    ST_RD      = 3'd7
  } sccb_tgt_state_t;

  // Value of the R/W bit (bit 0 of the device byte) for a register write.
  localparam logic        MODE_REG_WRITE   = 1'b0;
  localparam logic [6:0]  SCCB_ADDR_OV7670 = 7'h21;
  localparam logic [7:0]  WIRE_WR          = 8'h42;
  localparam logic [7:0]  WIRE_RD          = 8'h43;

  // Init-ROM escape codes used by the camera-init master.
  localparam logic [15:0] ROM_DELAY        = 16'hFFF0;
  localparam logic [15:0] ROM_END          = 16'hFFFF;

endpackage

// File: rtl/sccb_bus_sync.sv
// Synchronizes SCL/SDA into the clk domain and derives edge and bus-condition pulses.
module sccb_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_raw_i,
  input  logic sda_raw_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;

  // Synchronizer chains plus one history flop each; idle bus level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_raw_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_raw_i};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s       = scl_sync_q[SYNC_STAGES-1];
  assign sda_o       = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o  = scl_s & ~scl_prev_q;
  assign scl_fall_o  = ~scl_s & scl_prev_q;
  // SDA edges only count as START/STOP while SCL was and still is high.
  assign start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_o;
  assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_o;

endmodule

// File: rtl/sccb_target_regfile.sv
// SCCB/I2C target that turns bus register writes/reads into a simple register port.
// Register port: reg_wr_en is a one-clk strobe qualifying reg_addr/reg_wr_data;
// reg_rd_en is a one-clk request for reg_addr and reg_rd_data must be valid on the
// following clk, when it is captured into the transmit shift register.
module sccb_target_regfile
  import sccb_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = SCCB_ADDR_OV7670,
  parameter int         SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sccb_en,
  input  logic            SCL,
  inout  wire             SDA,
  output logic [7:0]      reg_addr,
  output logic            reg_wr_en,
  output logic [7:0]      reg_wr_data,
  output logic            reg_rd_en,
  input  logic [7:0]      reg_rd_data,
  output logic            busy,
  output logic            addr_hit,
  output sccb_tgt_state_t dbg_state
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  sccb_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .reset       (reset),
    .scl_raw_i   (SCL),
    .sda_raw_i   (SDA),
    .sda_o       (sda_s),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  sccb_tgt_state_t state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rw_q, rw_d;
  logic       ack_rise_q, ack_rise_d;   // SCL rise of the current ACK slot already seen
  logic       wr_en_q, wr_en_d;
  logic       rd_en_q, rd_en_d;
  logic       ld_pend_q;                // read data arrives this clk
  logic       busy_q, busy_d;
  logic       hit_q, hit_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_byte;

  assign rx_byte = {shift_q[6:0], sda_s};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      addr_q     <= 8'd0;
      wr_data_q  <= 8'd0;
      rw_q       <= 1'b0;
      ack_rise_q <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      ld_pend_q  <= 1'b0;
      busy_q     <= 1'b0;
      hit_q      <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      rw_q       <= rw_d;
      ack_rise_q <= ack_rise_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      ld_pend_q  <= rd_en_q;
      busy_q     <= busy_d;
      hit_q      <= hit_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  // Next-state logic: bus conditions first, then per-state bit handling on SCL edges.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    rw_d       = rw_q;
    ack_rise_d = ack_rise_q;
    busy_d     = busy_q;
    sda_oe_d   = sda_oe_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    hit_d      = 1'b0;

    if (ld_pend_q) shift_d = reg_rd_data;

    if (stop_det) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d    = ST_DEV;
      bit_cnt_d  = 4'd0;
      ack_rise_d = 1'b0;
      sda_oe_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_DEV, ST_REG, ST_WR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              ack_rise_d = 1'b0;
              if (state_q == ST_DEV) begin
                if (rx_byte[7:1] == TARGET_ADDR) begin
                  hit_d   = 1'b1;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                  state_d = ST_DEV_ACK;
                end else begin
                  state_d = ST_IDLE;
                end
              end else if (state_q == ST_REG) begin
                addr_d  = rx_byte;
                state_d = ST_REG_ACK;
              end else begin
                wr_data_d = rx_byte;
                wr_en_d   = 1'b1;
                state_d   = ST_WR_ACK;
              end
            end
          end
        end
        ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
          if (scl_fall && !ack_rise_q) begin
            sda_oe_d = !sccb_en;
          end else if (scl_rise) begin
            ack_rise_d = 1'b1;
            if (state_q == ST_DEV_ACK && rw_q != MODE_REG_WRITE) rd_en_d = 1'b1;
          end else if (scl_fall) begin
            ack_rise_d = 1'b0;
            bit_cnt_d  = 4'd0;
            sda_oe_d   = 1'b0;
            if (state_q == ST_DEV_ACK) begin
              if (rw_q != MODE_REG_WRITE) begin
                state_d  = ST_RD;
                sda_oe_d = !shift_q[7];
              end else begin
                state_d = ST_REG;
              end
            end else if (state_q == ST_REG_ACK) begin
              state_d = ST_WR;
            end else begin
              addr_d  = addr_q + 8'd1;
              state_d = ST_WR;
            end
          end
        end
        ST_RD: begin
          if (scl_rise) begin
            if (bit_cnt_q == 4'd8) begin
              if (!sda_s) begin
                addr_d     = addr_q + 8'd1;
                rd_en_d    = 1'b1;
                ack_rise_d = 1'b1;
                bit_cnt_d  = 4'd0;
              end else begin
                state_d  = ST_IDLE;
                sda_oe_d = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else if (scl_fall) begin
            if (ack_rise_q) begin
              ack_rise_d = 1'b0;
              sda_oe_d   = !shift_q[7];
            end else if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
            end else if (bit_cnt_q != 4'd0) begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = !shift_q[6];
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign SDA         = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_addr    = addr_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_data = wr_data_q;
  assign reg_rd_en   = rd_en_q;
  assign busy        = busy_q;
  assign addr_hit    = hit_q;
  assign dbg_state   = state_q;

endmodule
